// File: rtl/pmc_pkg.sv
// Shared types and constants for the PMC dump writer.
package pmc_pkg;

    typedef enum logic [1:0] {
        PMC_IDLE,
        PMC_WRITE,
        PMC_DONE
    } pmc_dump_state_t;

    localparam int PMC_NUM_METRICS = 4;
    localparam int PMC_M_STALL     = 0;
    localparam int PMC_M_CPI       = 1;
    localparam int PMC_M_ARITH     = 2;
    localparam int PMC_M_MEM       = 3;
    localparam int PMC_METRIC_W    = 256;
    localparam int PMC_WORD_W      = 32;

endpackage

// File: rtl/pmc_dump_writer_if.sv
// Valid/ready memory write port used to dump PMC snapshots.
interface pmc_dump_writer_if #(
    parameter int ADDR_W = 32
);
    logic              mem_wr_valid_out;
    logic              mem_wr_ready_in;
    logic [ADDR_W-1:0] mem_wr_addr_out;
    logic [31:0]       mem_wr_data_out;

    // Writer side drives the request, memory side answers with ready.
    modport master (
        output mem_wr_valid_out,
        output mem_wr_addr_out,
        output mem_wr_data_out,
        input  mem_wr_ready_in
    );

    modport slave (
        input  mem_wr_valid_out,
        input  mem_wr_addr_out,
        input  mem_wr_data_out,
        output mem_wr_ready_in
    );
endinterface

// File: rtl/pmc_dump_writer.sv
// Snapshots the four PMC metric buses on a dump request and writes them
// out as 32-bit words to a fixed memory region over a valid/ready port.
module pmc_dump_writer
    import pmc_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 'h0000_0400,
    parameter int                WORDS_PER_MET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dump_req_in,
    input  logic [PMC_METRIC_W-1:0] stall_count_in,
    input  logic [PMC_METRIC_W-1:0] cpi_q78_in,
    input  logic [PMC_METRIC_W-1:0] arith_count_in,
    input  logic [PMC_METRIC_W-1:0] mem_access_in,
    pmc_dump_writer_if.master       wr,
    output logic                    busy_out,
    output logic                    done_out
);

    localparam int                WIDX_W = (WORDS_PER_MET > 1) ? $clog2(WORDS_PER_MET) : 1;
    localparam logic [WIDX_W-1:0] LAST_W = WIDX_W'(WORDS_PER_MET - 1);
    localparam logic [1:0]        LAST_M = 2'(PMC_NUM_METRICS - 1);

    pmc_dump_state_t state_q, state_d;

    logic [PMC_NUM_METRICS-1:0][PMC_METRIC_W-1:0]                  met_in;
    logic [PMC_NUM_METRICS-1:0][WORDS_PER_MET-1:0][PMC_WORD_W-1:0] snap_q;
    logic [1:0]        met_q;
    logic [WIDX_W-1:0] wrd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              writing;
    logic              xfer;
    logic              last_word;
    logic              start;

    assign met_in[PMC_M_STALL] = stall_count_in;
    assign met_in[PMC_M_CPI]   = cpi_q78_in;
    assign met_in[PMC_M_ARITH] = arith_count_in;
    assign met_in[PMC_M_MEM]   = mem_access_in;

    assign writing   = (state_q == PMC_WRITE);
    assign xfer      = writing && wr.mem_wr_ready_in;
    assign last_word = (met_q == LAST_M) && (wrd_q == LAST_W);
    assign start     = (state_q == PMC_IDLE) && dump_req_in;

    // State register; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (reset) state_q <= PMC_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: requests outside IDLE are dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PMC_IDLE:  if (dump_req_in)       state_d = PMC_WRITE;
            PMC_WRITE: if (xfer && last_word) state_d = PMC_DONE;
            PMC_DONE:                         state_d = PMC_IDLE;
            default:                          state_d = PMC_IDLE;
        endcase
    end

    // Snapshot capture and word/address walk. The address is a running
    // byte pointer so it wraps modulo 2^ADDR_W with no extra logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q <= '0;
            met_q  <= '0;
            wrd_q  <= '0;
            addr_q <= BASE_ADDR;
        end else if (start) begin
            for (int m = 0; m < PMC_NUM_METRICS; m++)
                for (int w = 0; w < WORDS_PER_MET; w++)
                    snap_q[m][w] <= met_in[m][PMC_WORD_W*w +: PMC_WORD_W];
            met_q  <= '0;
            wrd_q  <= '0;
            addr_q <= BASE_ADDR;
        end else if (xfer) begin
            if (wrd_q == LAST_W) begin
                wrd_q <= '0;
                met_q <= met_q + 2'd1;
            end else begin
                wrd_q <= wrd_q + WIDX_W'(1);
            end
            addr_q <= addr_q + ADDR_W'(4);
        end
    end

    // Bus outputs are held at zero outside WRITE so idle/reset reads as all-zero.
    always_comb begin
        wr.mem_wr_valid_out = writing;
        wr.mem_wr_addr_out  = writing ? addr_q : '0;
        wr.mem_wr_data_out  = writing ? snap_q[met_q][wrd_q] : '0;
        busy_out            = writing;
        done_out            = (state_q == PMC_DONE);
    end

endmodule

// File: tb/tb_pmc_dump_writer.sv
// Directed bench for pmc_dump_writer: one instance with one word per metric,
// one with two words per metric.
module tb_pmc_dump_writer;
    import pmc_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         dreq_a = 1'b0;
    logic         dreq_b = 1'b0;
    logic [255:0] stall = '0, cpi = '0, arith = '0, mem = '0;
    logic         busy_a, done_a, busy_b, done_b;
    int           n_assert = 0;
    int           n_fail = 0;

    pmc_dump_writer_if #(.ADDR_W(32)) bus_a ();
    pmc_dump_writer_if #(.ADDR_W(32)) bus_b ();

    always #5 clk = ~clk;

    pmc_dump_writer #(.ADDR_W(32), .BASE_ADDR(32'h400), .WORDS_PER_MET(1)) dut_a (
        .clk(clk), .reset(reset), .dump_req_in(dreq_a),
        .stall_count_in(stall), .cpi_q78_in(cpi), .arith_count_in(arith), .mem_access_in(mem),
        .wr(bus_a.master), .busy_out(busy_a), .done_out(done_a)
    );

    pmc_dump_writer #(.ADDR_W(32), .BASE_ADDR(32'h400), .WORDS_PER_MET(2)) dut_b (
        .clk(clk), .reset(reset), .dump_req_in(dreq_b),
        .stall_count_in(stall), .cpi_q78_in(cpi), .arith_count_in(arith), .mem_access_in(mem),
        .wr(bus_b.master), .busy_out(busy_b), .done_out(done_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic beat_a(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_vld"},  64'(bus_a.mem_wr_valid_out), 64'd1);
        chk({tag, "_busy"}, 64'(busy_a), 64'd1);
        chk({tag, "_addr"}, 64'(bus_a.mem_wr_addr_out), 64'(a));
        chk({tag, "_data"}, 64'(bus_a.mem_wr_data_out), 64'(d));
    endtask

    task automatic done_chk_a(input string tag);
        chk({tag, "_done"}, 64'(done_a), 64'd1);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_vld"},  64'(bus_a.mem_wr_valid_out), 64'd0);
    endtask

    task automatic idle_a(input string tag);
        chk({tag, "_vld"},  64'(bus_a.mem_wr_valid_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_done"}, 64'(done_a), 64'd0);
        chk({tag, "_addr"}, 64'(bus_a.mem_wr_addr_out), 64'd0);
        chk({tag, "_data"}, 64'(bus_a.mem_wr_data_out), 64'd0);
    endtask

    logic [31:0] exp_addr_b [8];
    logic [31:0] exp_data_b [8];

    initial begin
        bus_a.mem_wr_ready_in = 1'b1;
        bus_b.mem_wr_ready_in = 1'b1;
        cyc(); cyc();
        idle_a("rst_a");
        chk("rst_b_vld",  64'(bus_b.mem_wr_valid_out), 64'd0);
        chk("rst_b_busy", 64'(busy_b), 64'd0);
        chk("rst_b_done", 64'(done_b), 64'd0);
        reset = 1'b0;
        cyc();

        // 1: basic dump, ready tied high
        stall = 256'd7; cpi = 256'h280; arith = 256'd42; mem = 256'd9;
        dreq_a = 1'b1; cyc(); dreq_a = 1'b0;
        beat_a("t1_w0", 32'h400, 32'd7);    cyc();
        beat_a("t1_w1", 32'h404, 32'h280);  cyc();
        beat_a("t1_w2", 32'h408, 32'd42);   cyc();
        beat_a("t1_w3", 32'h40C, 32'd9);    cyc();
        done_chk_a("t1_end");               cyc();
        idle_a("t1_idle");

        // 2: three cycles of backpressure on word 2
        dreq_a = 1'b1; cyc(); dreq_a = 1'b0;
        beat_a("t2_w0", 32'h400, 32'd7);    cyc();
        beat_a("t2_w1", 32'h404, 32'h280);  cyc();
        bus_a.mem_wr_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat_a("t2_stall", 32'h408, 32'd42); cyc();
        end
        bus_a.mem_wr_ready_in = 1'b1;
        beat_a("t2_w2", 32'h408, 32'd42);   cyc();
        beat_a("t2_w3", 32'h40C, 32'd9);    cyc();
        done_chk_a("t2_end");               cyc();
        idle_a("t2_idle");

        // 3: inputs change right after the snapshot edge
        dreq_a = 1'b1; cyc(); dreq_a = 1'b0;
        stall = 256'hFFFF; cpi = 256'hFFFF; arith = 256'hFFFF; mem = 256'hFFFF;
        beat_a("t3_w0", 32'h400, 32'd7);    cyc();
        beat_a("t3_w1", 32'h404, 32'h280);  cyc();
        beat_a("t3_w2", 32'h408, 32'd42);   cyc();
        beat_a("t3_w3", 32'h40C, 32'd9);    cyc();
        done_chk_a("t3_end");               cyc();
        idle_a("t3_idle");

        // 4: request during WRITE is dropped
        stall = 256'd7; cpi = 256'h280; arith = 256'd42; mem = 256'd9;
        dreq_a = 1'b1; cyc(); dreq_a = 1'b0;
        beat_a("t4_w0", 32'h400, 32'd7);    cyc();
        beat_a("t4_w1", 32'h404, 32'h280);
        dreq_a = 1'b1; cyc(); dreq_a = 1'b0;
        beat_a("t4_w2", 32'h408, 32'd42);   cyc();
        beat_a("t4_w3", 32'h40C, 32'd9);    cyc();
        done_chk_a("t4_end");               cyc();
        idle_a("t4_idle0");                 cyc();
        idle_a("t4_idle1");

        // 6: reset during word 1 aborts, next dump restarts at base
        dreq_a = 1'b1; cyc(); dreq_a = 1'b0;
        beat_a("t6_w0", 32'h400, 32'd7);    cyc();
        beat_a("t6_w1", 32'h404, 32'h280);
        reset = 1'b1; cyc();
        idle_a("t6_rst");
        reset = 1'b0; cyc();
        idle_a("t6_post0");                 cyc();
        idle_a("t6_post1");
        dreq_a = 1'b1; cyc(); dreq_a = 1'b0;
        beat_a("t6_r0", 32'h400, 32'd7);    cyc();
        beat_a("t6_r1", 32'h404, 32'h280);  cyc();
        beat_a("t6_r2", 32'h408, 32'd42);   cyc();
        beat_a("t6_r3", 32'h40C, 32'd9);    cyc();
        done_chk_a("t6_end");               cyc();

        // 5: two words per metric on the second instance
        stall = '0; cpi = '0; arith = '0; mem = '0;
        stall[63:0] = 64'h0000_000B_0000_000A;
        cpi[63:0]   = 64'h0000_000D_0000_000C;
        arith[63:0] = 64'h0000_000F_0000_000E;
        mem[63:0]   = 64'h0000_0011_0000_0010;
        exp_data_b = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF, 32'h10, 32'h11};
        exp_addr_b = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h414, 32'h418, 32'h41C};
        dreq_b = 1'b1; cyc(); dreq_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_w%0d_vld", i),  64'(bus_b.mem_wr_valid_out), 64'd1);
            chk($sformatf("t5_w%0d_addr", i), 64'(bus_b.mem_wr_addr_out), 64'(exp_addr_b[i]));
            chk($sformatf("t5_w%0d_data", i), 64'(bus_b.mem_wr_data_out), 64'(exp_data_b[i]));
            cyc();
        end
        chk("t5_done",     64'(done_b), 64'd1);
        chk("t5_done_vld", 64'(bus_b.mem_wr_valid_out), 64'd0);
        cyc();
        chk("t5_idle_vld",  64'(bus_b.mem_wr_valid_out), 64'd0);
        chk("t5_idle_done", 64'(done_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
